mux_cfg_shadow_chain: RTL

- Configuration-chain segment that drives the mem/mem_inv select pins of one TGATE-based routing or LUT multiplexer.
- Bits shift in serially from the upstream chain and pass out to the downstream chain.
- A full frame is held in a shift register, then committed atomically into a shadow register that drives mem and mem_inv. The mux select lines never glitch during programming.

---
 rtl/mux_cfg_shadow_chain.sv | 103 ++++++++++
 1 files changed

// File: rtl/mux_cfg_shadow_chain.sv
// Config-chain segment: serial shift register committed atomically into a mem/mem_inv shadow (optional contention check: MUX_CFG_ONEHOT_CHECK_EN).
// ccff_tail = sr[MEM_SIZE-1]; mem updates 1 cycle after an accepted commit; rejected commits pulse frame_err and change nothing.
module mux_cfg_shadow_chain #(
    parameter int                  MEM_SIZE      = 8,
    parameter logic [MEM_SIZE-1:0] MEM_RESET_VAL = '0
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                ccff_head,
    input  logic                shift_en,
    input  logic                commit,
    output logic                ccff_tail,
    output logic [0:MEM_SIZE-1] mem,
    output logic [0:MEM_SIZE-1] mem_inv,
    output logic                cfg_valid,
    output logic                frame_err,
    output logic                onehot_err
);

    localparam int                  CW      = $clog2(MEM_SIZE + 1);
    localparam logic [CW-1:0]       CNT_MAX = CW'(MEM_SIZE);
    localparam logic [CW-1:0]       CNT_ONE = CW'(1);
    localparam logic [MEM_SIZE-1:0] SR_ONE  = MEM_SIZE'(1);
`ifdef MUX_CFG_ONEHOT_CHECK_EN
    localparam bit ONEHOT_EN = (MEM_SIZE > 1);
`else
    localparam bit ONEHOT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t              r_state;
    logic [MEM_SIZE-1:0] r_sr;
    logic [MEM_SIZE-1:0] r_mem;
    logic [MEM_SIZE-1:0] r_mem_inv;
    logic [CW-1:0]       r_cnt;
    logic                r_cfg_valid;
    logic                r_frame_err;
    logic                r_onehot_err;

    logic [MEM_SIZE-1:0] w_sr_shift;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_contention;
    logic                w_commit_ok;

    always_comb begin
        w_sr_shift    = r_sr << 1;
        w_sr_shift[0] = ccff_head;
    end

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    // More than one set bit means several TGATEs would drive the shared output net.
    generate
        if (ONEHOT_EN) begin : g_onehot
            assign w_contention = |(r_sr & (r_sr - SR_ONE));
        end else begin : g_no_onehot
            assign w_contention = 1'b0;
        end
    endgenerate

    assign w_commit_ok = commit && !shift_en && (r_state == ST_READY) && !w_contention;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state      <= ST_IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_mem        <= MEM_RESET_VAL;
            r_mem_inv    <= ~MEM_RESET_VAL;
            r_cfg_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_onehot_err <= 1'b0;
        end else begin
            r_frame_err  <= commit && !w_commit_ok;
            r_onehot_err <= commit && !shift_en && (r_state == ST_READY) && w_contention;
            if (shift_en) begin
                r_sr    <= w_sr_shift;
                r_cnt   <= w_cnt_inc;
                r_state <= (w_cnt_inc == CNT_MAX) ? ST_READY : ST_SHIFT;
            end else if (w_commit_ok) begin
                // sr is kept so the frame can still be read out downstream
                r_mem       <= r_sr;
                r_mem_inv   <= ~r_sr;
                r_cfg_valid <= 1'b1;
                r_cnt       <= '0;
                r_state     <= ST_IDLE;
            end
        end
    end

    assign ccff_tail  = r_sr[MEM_SIZE-1];
    assign mem        = r_mem;
    assign mem_inv    = r_mem_inv;
    assign cfg_valid  = r_cfg_valid;
    assign frame_err  = r_frame_err;
    assign onehot_err = ONEHOT_EN ? r_onehot_err : 1'b0;

endmodule
